// File: rtl/vsm4_core_if.sv
// Bus bundle between the vsm4 core and its surroundings (program memory, I/O port, debug taps).
interface vsm4_core_if;
  logic [7:0] ProgData;
  logic [3:0] DataIn;
  logic [3:0] ProgAddr;
  logic [3:0] DataOut;
  logic [3:0] IB;
  logic [1:0] Phase;

  modport master (
    input  ProgData, DataIn,
    output ProgAddr, DataOut, IB, Phase
  );

  modport slave (
    output ProgData, DataIn,
    input  ProgAddr, DataOut, IB, Phase
  );
endinterface

// File: rtl/vsm4_core.sv
// 4-bit accumulator core: fixed fetch / PC-increment / execute / write-back cycle,
// every register load goes through the single internal bus IB.
module vsm4_core (
  input logic         MainClock,
  input logic         MainClear,
  vsm4_core_if.master bus
);
  typedef enum logic [1:0] {T1 = 2'd0, T2 = 2'd1, T3 = 2'd2, T4 = 2'd3} phase_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_OUT  = 4'h3;
  localparam logic [3:0] OP_IN   = 4'h4;
  localparam logic [3:0] OP_LOAD = 4'h5;

  phase_t     phase, phase_nxt;
  logic [7:0] ir;
  logic [3:0] pc, a, b, dout;
  logic [3:0] ib, alu;
  logic [3:0] opcode, operand;
  logic       ld_ir, inc_pc, ld_a, ld_b, ld_out;

  assign opcode  = ir[7:4];
  assign operand = ir[3:0];
  // Subtract as A + ~B + 1 so both ops share one adder; carry/borrow drop off the top.
  assign alu = (opcode == OP_SUB) ? (a + ~b + 4'd1) : (a + b);

  always_ff @(posedge MainClock or negedge MainClear) begin
    if (!MainClear) phase <= T1;
    else            phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    ib        = 4'h0;
    ld_ir     = 1'b0;
    inc_pc    = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_out    = 1'b0;
    unique case (phase)
      T1: begin
        phase_nxt = T2;
        ld_ir     = 1'b1;
      end
      T2: begin
        phase_nxt = T3;
        inc_pc    = 1'b1;
      end
      T3: begin
        phase_nxt = T4;
        case (opcode)
          OP_ADD, OP_SUB: begin ib = operand;    ld_b   = 1'b1; end
          OP_LOAD:        begin ib = operand;    ld_a   = 1'b1; end
          OP_IN:          begin ib = bus.DataIn; ld_a   = 1'b1; end
          OP_OUT:         begin ib = a;          ld_out = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        phase_nxt = T1;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ib   = alu;
          ld_a = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge MainClock or negedge MainClear) begin
    if (!MainClear) begin
      ir   <= 8'h00;
      pc   <= 4'h0;
      a    <= 4'h0;
      b    <= 4'h0;
      dout <= 4'h0;
    end else begin
      if (ld_ir)  ir   <= bus.ProgData;
      if (inc_pc) pc   <= pc + 4'd1;
      if (ld_a)   a    <= ib;
      if (ld_b)   b    <= ib;
      if (ld_out) dout <= ib;
    end
  end

  assign bus.ProgAddr = pc;
  assign bus.DataOut  = dout;
  assign bus.IB       = ib;
  assign bus.Phase    = phase;
endmodule

// File: tb/tb_vsm4_core.sv
// Bench for vsm4_core: instruction-level reference model, directed programs plus a random program.
module tb_vsm4_core;
  logic MainClock = 1'b0;
  logic MainClear = 1'b0;
  vsm4_core_if bus ();

  logic [7:0] mem [16];
  assign bus.ProgData = mem[bus.ProgAddr];

  vsm4_core dut (.MainClock(MainClock), .MainClear(MainClear), .bus(bus));

  always #5 MainClock = ~MainClock;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [3:0] m_a, m_pc, m_out;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rnd_instr();
    logic [3:0] op;
    op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
    return {op, 4'($urandom)};
  endfunction

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 8'h00;
  endtask

  // Assert reset, check the cleared state, release just after a falling edge.
  task automatic do_reset();
    MainClear = 1'b0;
    #3;
    chk("rst_phase", {6'd0, bus.Phase}, 8'd0);
    chk("rst_pc",    {4'd0, bus.ProgAddr}, 8'd0);
    chk("rst_out",   {4'd0, bus.DataOut}, 8'd0);
    chk("rst_ib",    {4'd0, bus.IB}, 8'd0);
    @(negedge MainClock);
    MainClear = 1'b1;
    m_a = 4'h0; m_pc = 4'h0; m_out = 4'h0;
  endtask

  // One whole instruction, starting just after a falling edge in T1.
  task automatic run_instr(input logic [3:0] din, input bit garble);
    logic [7:0] ir;
    logic [3:0] op, opd, e3, e4;
    ir  = mem[m_pc];
    op  = ir[7:4];
    opd = ir[3:0];
    e3  = 4'h0;
    e4  = 4'h0;
    case (op)
      4'h1: begin e3 = opd; e4 = m_a + opd; end
      4'h2: begin e3 = opd; e4 = m_a - opd; end
      4'h3: e3 = m_a;
      4'h4: e3 = din;
      4'h5: e3 = opd;
      default: ;
    endcase
    bus.DataIn = 4'($urandom);
    #1;
    chk("t1_phase", {6'd0, bus.Phase}, 8'd0);
    chk("t1_pc",    {4'd0, bus.ProgAddr}, {4'd0, m_pc});
    chk("t1_ib",    {4'd0, bus.IB}, 8'd0);
    @(negedge MainClock);
    if (garble) mem[m_pc] = rnd_instr();
    bus.DataIn = 4'($urandom);
    #1;
    chk("t2_phase", {6'd0, bus.Phase}, 8'd1);
    chk("t2_ib",    {4'd0, bus.IB}, 8'd0);
    @(negedge MainClock);
    bus.DataIn = din;
    #1;
    chk("t3_phase", {6'd0, bus.Phase}, 8'd2);
    chk("t3_pc",    {4'd0, bus.ProgAddr}, {4'd0, 4'(m_pc + 4'd1)});
    chk("t3_ib",    {4'd0, bus.IB}, {4'd0, e3});
    @(negedge MainClock);
    bus.DataIn = 4'($urandom);
    #1;
    chk("t4_phase", {6'd0, bus.Phase}, 8'd3);
    chk("t4_ib",    {4'd0, bus.IB}, {4'd0, e4});
    case (op)
      4'h1, 4'h2: m_a = e4;
      4'h3:       m_out = m_a;
      4'h4, 4'h5: m_a = e3;
      default: ;
    endcase
    m_pc = m_pc + 4'd1;
    @(negedge MainClock);
    chk("dataout", {4'd0, bus.DataOut}, {4'd0, m_out});
  endtask

  initial begin
    bus.DataIn = 4'h0;
    clear_mem();

    // All-Nop program, long enough to wrap the PC.
    do_reset();
    repeat (18) run_instr(4'($urandom), 1'b0);

    // Load 5, Out
    clear_mem();
    mem[0] = 8'h55; mem[1] = 8'h30;
    do_reset();
    repeat (2) run_instr(4'h0, 1'b0);
    chk("load_out", {4'd0, bus.DataOut}, 8'h05);

    // Load 5, Add 3, Out
    clear_mem();
    mem[0] = 8'h55; mem[1] = 8'h13; mem[2] = 8'h30;
    do_reset();
    repeat (3) run_instr(4'h0, 1'b0);
    chk("add_out", {4'd0, bus.DataOut}, 8'h08);

    // Load 2, Sub 9, Out, Load F, Add 1, Out
    clear_mem();
    mem[0] = 8'h52; mem[1] = 8'h29; mem[2] = 8'h30;
    mem[3] = 8'h5F; mem[4] = 8'h11; mem[5] = 8'h30;
    do_reset();
    repeat (3) run_instr(4'h0, 1'b0);
    chk("sub_wrap", {4'd0, bus.DataOut}, 8'h09);
    repeat (3) run_instr(4'h0, 1'b0);
    chk("add_wrap", {4'd0, bus.DataOut}, 8'h00);

    // In A, Out, then Nop-class opcodes leave everything alone
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'h30; mem[2] = 8'h63;
    mem[3] = 8'hF9; mem[4] = 8'h8C; mem[5] = 8'h30;
    do_reset();
    repeat (2) run_instr(4'hA, 1'b0);
    chk("in_out", {4'd0, bus.DataOut}, 8'h0A);
    repeat (4) run_instr(4'h3, 1'b0);
    chk("nop_ops", {4'd0, bus.DataOut}, 8'h0A);

    // Random program, with the fetched word overwritten after each fetch
    foreach (mem[i]) mem[i] = rnd_instr();
    do_reset();
    repeat (48) run_instr(4'($urandom), 1'b1);

    // Reset in the T4 of an Add abandons it and clears everything
    clear_mem();
    mem[0] = 8'h57; mem[1] = 8'h30; mem[2] = 8'h13;
    do_reset();
    repeat (2) run_instr(4'h0, 1'b0);
    chk("pre_rst_out", {4'd0, bus.DataOut}, 8'h07);
    repeat (3) @(negedge MainClock);
    #1;
    chk("mid_phase", {6'd0, bus.Phase}, 8'd3);
    chk("mid_ib",    {4'd0, bus.IB}, 8'h0A);
    MainClear = 1'b0;
    #1;
    chk("mid_rst_phase", {6'd0, bus.Phase}, 8'd0);
    chk("mid_rst_pc",    {4'd0, bus.ProgAddr}, 8'd0);
    chk("mid_rst_out",   {4'd0, bus.DataOut}, 8'd0);
    chk("mid_rst_ib",    {4'd0, bus.IB}, 8'd0);
    mem[0] = 8'h30; mem[1] = 8'h13; mem[2] = 8'h30;
    @(negedge MainClock);
    MainClear = 1'b1;
    m_a = 4'h0; m_pc = 4'h0; m_out = 4'h0;
    run_instr(4'h0, 1'b0);
    chk("post_rst_a", {4'd0, bus.DataOut}, 8'h00);
    repeat (2) run_instr(4'h0, 1'b0);
    chk("post_rst_add", {4'd0, bus.DataOut}, 8'h03);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vsm4_core.md
Name: vsm4_core

Overview:
- 4-bit accumulator microprocessor core built around one internal 4-bit bus.
- Each instruction runs a fixed 4-phase cycle: fetch, PC increment, execute, ALU write-back.
- Fetches 8-bit instructions from an external program memory, reads a 4-bit input port, and drives a registered 4-bit output port.
- Top-level compute block of the VSM design; the program memory sits outside it.

Parameters:
None. Datapath width is fixed at 4 bits, program address at 4 bits, instruction word at 8 bits.

Ports:
MainClock  input  1  rising-edge clock
MainClear  input  1  asynchronous active-low reset
ProgData   input  8  instruction word at ProgAddr (combinational read); [7:4] opcode, [3:0] operand
DataIn     input  4  input port, sampled by In
ProgAddr   output 4  program counter value
DataOut    output 4  output register, written by Out
IB         output 4  current internal bus value (debug/observe)
Phase      output 2  sequencer phase: 0=T1, 1=T2, 2=T3, 3=T4

Behaviour:
- Reset (MainClear=0, asynchronous) clears:
  - Phase to T1.
  - PC, IR (8b), A (accumulator), B (operand register) and DataOut to 0.
- Reset dominates the clock.
- On release, the first rising edge performs T1.
- The sequencer advances T1->T2->T3->T4->T1 on every rising edge, with no stalls. One instruction takes exactly 4 clocks.
- T1 edge: IR <= ProgData.
- T2 edge: PC <= PC+1 mod 16 (15 wraps to 0).
- Opcodes, taken from IR[7:4]:
  - 0000 Nop: no state change.
  - 0001 Add: T3 B <= operand; T4 A <= A+B mod 16.
  - 0010 Sub: T3 B <= operand; T4 A <= A+~B+1 mod 16, i.e. A-B wrapping.
  - 0011 Out: T3 DataOut <= A.
  - 0100 In: T3 A <= DataIn.
  - 0101 Load: T3 A <= operand.
  - All other codes (0110-1111, including any with bit 3 set) behave as Nop.
- Carry and borrow are discarded; there are no flags.
- IB is combinational and has a single source per phase:
  - T3: operand for Add, Sub and Load; DataIn for In; A for Out.
  - T4: ALU result for Add and Sub.
  - Otherwise 0000.
- Registers update only at the edge ending the phase; IB shows the value about to be captured.
- DataOut holds its value until the next Out or reset.
- A mid-instruction reset abandons the instruction. No partial write survives, since all state is cleared.
- ProgData is sampled only at the T1 edge; changes at other times are ignored.
- DataIn is sampled only at the T3 edge of In.

Test Plan:
- Reset then release with ProgData=0x00 -> Phase cycles 0,1,2,3,0.
  - ProgAddr increments once per 4 clocks.
  - A, DataOut and IB stay 0.
- Program Load 5 (0x55), Out (0x30) -> after 8 clocks DataOut=0x5.
  - IB=0x5 during the T3 of each instruction.
- Program Load 5, Add 3 (0x13), Out -> DataOut=0x8.
  - B=0x3, and IB=0x8 in the Add T4.
- Program Load 2, Sub 9 (0x29), Out -> DataOut=0x9 (2-9 mod 16).
  - Also: Load F, Add 1, Out -> DataOut=0x0 (wrap).
- Program In (0x40) with DataIn=0xA, Out -> DataOut=0xA.
  - DataIn changes outside T3 are ignored.
- Opcodes 0x6X and 0xFX -> no change to A, B or DataOut.
- PC advances past 15 -> ProgAddr=0.
- MainClear asserted during T4 of an Add -> all registers 0 immediately, Phase=T1.
